// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding, tap/latency defaults and delay-line address helper
package fir_pkg;

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_MAC   = 3'd2,
      S_DRAIN = 3'd3,
      S_OUT   = 3'd4
   } state_e;

   localparam int NTAPS_DEF    = 8;
   localparam int PIPE_LAT_DEF = 2;

   // Circular step back by k from base in an n-deep ring; exact for any n, not only powers of two
   function automatic int wrap_sub(input int base, input int k, input int n);
      return (base >= k) ? base - k : base + n - k;
   endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if: sample/result handshakes plus delay-line, coefficient and accumulator controls
interface fir_mac_sequencer_if #(parameter int AW = 3);

   logic          in_valid;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic          dl_we;
   logic          dl_zero;
   logic [AW-1:0] dl_waddr;
   logic          rd_en;
   logic [AW-1:0] dl_raddr;
   logic [AW-1:0] coef_addr;
   logic          acc_load;
   logic          acc_en;
   logic [2:0]    state;

   modport master (
      input  in_valid, out_ready,
      output in_ready, out_valid, dl_we, dl_zero, dl_waddr, rd_en,
             dl_raddr, coef_addr, acc_load, acc_en, state
   );

   modport slave (
      output in_valid, out_ready,
      input  in_ready, out_valid, dl_we, dl_zero, dl_waddr, rd_en,
             dl_raddr, coef_addr, acc_load, acc_en, state
   );

endinterface

// File: rtl/fir_ctrl_delay.sv
// fir_ctrl_delay: DEPTH-stage flag delay matching the multiplier pipe, cleared asynchronously
module fir_ctrl_delay #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [DEPTH-1:0] sr_q;

   // Shift the flag one stage per cycle; the cast drops the oldest bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= '0;
      else        sr_q <= DEPTH'({sr_q, d_i});
   end

   assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: zero-fills the delay line, then per sample walks all taps through the MAC pipe
module fir_mac_sequencer
   import fir_pkg::*;
#(
   parameter  int NTAPS    = NTAPS_DEF,
   parameter  int PIPE_LAT = PIPE_LAT_DEF,
   localparam int AW       = $clog2(NTAPS)
) (
   input logic                  clk,
   input logic                  rst_n,
   fir_mac_sequencer_if.master  bus
);

   state_e        state_q;
   logic          armed_q;
   logic [AW-1:0] cnt_q;
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] base_q;
   logic [2:0]    dcnt_q;
   logic          is_init, is_idle, is_mac, is_out;
   logic          first_tap, pipe_v, pipe_first;

   assign is_init = armed_q && state_q == S_INIT;
   assign is_idle = armed_q && state_q == S_IDLE;
   assign is_mac  = armed_q && state_q == S_MAC;
   assign is_out  = armed_q && state_q == S_OUT;

   // Control FSM; nothing advances until armed has set on the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         armed_q <= 1'b0;
         cnt_q   <= '0;
         wptr_q  <= '0;
         base_q  <= '0;
         dcnt_q  <= '0;
      end else begin
         armed_q <= 1'b1;
         if (armed_q) begin
            case (state_q)
               S_INIT: begin
                  cnt_q <= (cnt_q == AW'(NTAPS-1)) ? '0 : cnt_q + AW'(1);
                  if (cnt_q == AW'(NTAPS-1)) state_q <= S_IDLE;
               end
               S_IDLE: begin
                  if (bus.in_valid) begin
                     base_q  <= wptr_q;
                     wptr_q  <= (wptr_q == AW'(NTAPS-1)) ? '0 : wptr_q + AW'(1);
                     cnt_q   <= '0;
                     state_q <= S_MAC;
                  end
               end
               S_MAC: begin
                  cnt_q  <= (cnt_q == AW'(NTAPS-1)) ? '0 : cnt_q + AW'(1);
                  dcnt_q <= '0;
                  if (cnt_q == AW'(NTAPS-1)) state_q <= S_DRAIN;
               end
               S_DRAIN: begin
                  dcnt_q <= dcnt_q + 3'd1;
                  if (dcnt_q == 3'(PIPE_LAT-1)) state_q <= S_OUT;
               end
               S_OUT: begin
                  if (bus.out_ready) state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign first_tap = is_mac && cnt_q == '0;

   fir_ctrl_delay #(.DEPTH(PIPE_LAT)) u_rd_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (is_mac),
      .q_o   (pipe_v)
   );

   fir_ctrl_delay #(.DEPTH(PIPE_LAT)) u_first_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (first_tap),
      .q_o   (pipe_first)
   );

   assign bus.in_ready  = is_idle;
   assign bus.out_valid = is_out;
   assign bus.dl_we     = is_init || (is_idle && bus.in_valid);
   assign bus.dl_zero   = is_init;
   assign bus.dl_waddr  = is_init ? cnt_q : (is_idle ? wptr_q : '0);
   assign bus.rd_en     = is_mac;
   assign bus.dl_raddr  = is_mac ? AW'(wrap_sub(int'(base_q), int'(cnt_q), NTAPS)) : '0;
   assign bus.coef_addr = is_mac ? cnt_q : '0;
   assign bus.acc_load  = pipe_first;
   assign bus.acc_en    = pipe_v && !pipe_first;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed checks of init fill, MAC walk, wrap, backpressure, streaming and mid-run reset
module tb_fir_mac_sequencer;

   localparam int NT = 8;
   localparam int PL = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   fir_mac_sequencer_if #(.AW(3)) bus ();

   fir_mac_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic int outs();
      return int'({bus.in_ready, bus.out_valid, bus.dl_we, bus.dl_zero, bus.dl_waddr, bus.rd_en,
                   bus.dl_raddr, bus.coef_addr, bus.acc_load, bus.acc_en, bus.state});
   endfunction

   task automatic init_fill();
      for (int i = 0; i < NT; i++) begin
         @(negedge clk); #1;
         chk("init_we", int'(bus.dl_we), 1);
         chk("init_zero", int'(bus.dl_zero), 1);
         chk("init_waddr", int'(bus.dl_waddr), i);
         chk("init_in_ready", int'(bus.in_ready), 0);
         chk("init_acc", int'(bus.acc_en | bus.acc_load), 0);
      end
      @(negedge clk); #1;
      chk("idle_in_ready", int'(bus.in_ready), 1);
      chk("idle_state", int'(bus.state), 1);
   endtask

   task automatic transact(input int base, input int hold);
      int last;
      last = NT + PL + 1 + hold;
      bus.in_valid = 1'b1;
      #1;
      chk("acc_in_ready", int'(bus.in_ready), 1);
      chk("acc_we", int'(bus.dl_we), 1);
      chk("acc_zero", int'(bus.dl_zero), 0);
      chk("acc_waddr", int'(bus.dl_waddr), base);
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         bus.in_valid  = (c <= NT + PL);
         bus.out_ready = (c <= NT + PL) || (c >= NT + PL + 1 + hold);
         #1;
         chk("rd_en", int'(bus.rd_en), int'(c <= NT));
         if (c <= NT) begin
            chk("coef_addr", int'(bus.coef_addr), c - 1);
            chk("dl_raddr", int'(bus.dl_raddr), (base - (c - 1) + NT) % NT);
         end
         chk("acc_load", int'(bus.acc_load), int'(c == 1 + PL));
         chk("acc_en", int'(bus.acc_en), int'(c > 1 + PL && c <= NT + PL));
         chk("out_valid", int'(bus.out_valid), int'(c > NT + PL));
         chk("busy_we", int'(bus.dl_we), 0);
         chk("busy_in_ready", int'(bus.in_ready), 0);
         chk("busy_state", int'(bus.state), c <= NT ? 2 : (c <= NT + PL ? 3 : 4));
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      chk("back_idle", int'(bus.state), 1);
      chk("back_in_ready", int'(bus.in_ready), 1);
   endtask

   initial begin
      int n_acc, n_ld, n_out, prev;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      #1;
      chk("reset_outs", outs(), 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("release_outs", outs(), 0);
      init_fill();

      transact(0, 0);
      transact(1, 5);
      for (int s = 2; s < NT; s++) transact(s, 0);
      transact(0, 0);
      transact(1, 0);
      transact(2, 0);

      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      n_acc = 0; n_ld = 0; n_out = 0; prev = 0;
      for (int c = 0; c <= 5 * (NT + PL + 2); c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (bus.in_ready) begin
            if (n_acc > 0) chk("stream_gap", c - prev, NT + PL + 2);
            prev = c;
            n_acc++;
         end
         n_ld  += int'(bus.acc_load);
         n_out += int'(bus.out_valid);
      end
      chk("stream_accepts", n_acc, 6);
      chk("stream_loads", n_ld, 5);
      chk("stream_outs", n_out, 5);

      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         #1;
      end
      chk("pre_rst_k", int'(bus.coef_addr), 4);
      chk("pre_rst_rd", int'(bus.rd_en), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_outs", outs(), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rerelease_outs", outs(), 0);
      init_fill();
      transact(0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
